// File: rtl/cclk_driver.sv
// Transmitting end of the cclk configuration/ready line: shifts bytes MSB-first
// on dout under a divided cclk, or parks cclk high to signal ready to the peer.
module cclk_driver #(
  parameter int CLK_RATE    = 50000000,
  parameter int CCLK_RATE   = 1000000,
  parameter int HOLD_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       new_data,
  input  logic       done,
  input  logic       abort,
  output logic       busy,
  output logic       cclk,
  output logic       dout,
  output logic       ready_sent
);

  localparam int HALF = CLK_RATE / (2 * CCLK_RATE);
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(HALF - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, READY} state_t;

  state_t        r_state, w_nextState;
  logic [7:0]    r_shift, w_shift;
  logic [2:0]    r_bitIdx, w_bitIdx;
  logic [PW-1:0] r_phase, w_phase;
  logic [HW-1:0] r_hold, w_hold;
  logic          r_cclk, w_cclk;
  logic          r_dout, w_dout;
  logic          r_busy, w_busy;
  logic          r_ready, w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_phase  <= '0;
      r_hold   <= '0;
      r_cclk   <= 1'b0;
      r_dout   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_shift  <= w_shift;
      r_bitIdx <= w_bitIdx;
      r_phase  <= w_phase;
      r_hold   <= w_hold;
      r_cclk   <= w_cclk;
      r_dout   <= w_dout;
      r_busy   <= w_busy;
      r_ready  <= w_ready;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_shift     = r_shift;
    w_bitIdx    = r_bitIdx;
    w_phase     = r_phase;
    w_hold      = r_hold;
    w_cclk      = r_cclk;
    w_dout      = r_dout;
    w_ready     = r_ready;

    if (abort) begin
      w_nextState = IDLE;
      w_cclk      = 1'b0;
      w_ready     = 1'b0;
      w_phase     = '0;
      w_hold      = '0;
      w_dout      = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cclk = 1'b0;
          if (new_data) begin
            w_shift     = data_in;
            w_dout      = data_in[7];
            w_bitIdx    = 3'd7;
            w_phase     = '0;
            w_nextState = SHIFT;
          end else if (done) begin
            w_cclk      = 1'b1;
            w_hold      = '0;
            w_nextState = HOLD;
          end
        end
        SHIFT: begin
          if (r_phase == PH_LAST) begin
            w_phase = '0;
            if (!r_cclk) begin
              w_cclk = 1'b1;
            end else begin
              // Falling edge: present the next bit, or finish after bit0 went out.
              w_cclk = 1'b0;
              if (r_bitIdx == 3'd0) begin
                w_nextState = IDLE;
              end else begin
                w_bitIdx = r_bitIdx - 3'd1;
                w_dout   = r_shift[r_bitIdx - 3'd1];
              end
            end
          end else begin
            w_phase = r_phase + 1'b1;
          end
        end
        HOLD: begin
          w_cclk = 1'b1;
          if (r_hold == HOLD_LAST) begin
            w_ready     = 1'b1;
            w_nextState = READY;
          end else begin
            w_hold = r_hold + 1'b1;
          end
        end
        READY: begin
          w_cclk  = 1'b1;
          w_ready = 1'b1;
        end
        default: w_nextState = IDLE;
      endcase
    end

    w_busy = (w_nextState != IDLE);
  end

  assign busy       = r_busy;
  assign cclk       = r_cclk;
  assign dout       = r_dout;
  assign ready_sent = r_ready;

endmodule

// File: tb/tb_cclk_driver.sv
// Directed bench for cclk_driver with HALF=25 and HOLD_CYCLES=16; expected
// values are hand-derived from the byte timing and the hold length.
module tb_cclk_driver;

  localparam int HALF = 25;
  localparam int HOLD = 16;

  logic       clk;
  logic       rstN;
  logic [7:0] dataIn;
  logic       newData;
  logic       doneIn;
  logic       abortIn;
  logic       busy;
  logic       cclk;
  logic       dout;
  logic       readySent;

  int compared;
  int mismatched;
  int cyc;
  int startCyc;
  int endCyc;
  int prevEnd;

  cclk_driver #(
    .CLK_RATE(50000000),
    .CCLK_RATE(1000000),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rstN),
    .data_in(dataIn),
    .new_data(newData),
    .done(doneIn),
    .abort(abortIn),
    .busy(busy),
    .cclk(cclk),
    .dout(dout),
    .ready_sent(readySent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobes one byte (optionally with done in the same cycle, or done mid-byte)
  // and checks the rising-edge samples, pulse count and busy length.
  task automatic applyStimulus(input logic [7:0] b, input bit withDone, input bit doneMid, input string tag);
    logic [7:0] got;
    logic       prevC;
    int         rises;
    int         busyCyc;
    dataIn  = b;
    newData = 1'b1;
    doneIn  = withDone;
    tick();
    newData = 1'b0;
    doneIn  = 1'b0;
    startCyc = cyc;
    checkOutput({tag, " start busy"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, " start dout"}, {31'b0, dout}, {31'b0, b[7]});
    checkOutput({tag, " start cclk"}, {31'b0, cclk}, 32'd0);
    got = '0;
    rises = 0;
    busyCyc = 1;
    prevC = cclk;
    for (int i = 0; i < 16 * HALF + 20 && busy; i++) begin
      if (doneMid && i == 50) doneIn = 1'b1;
      tick();
      doneIn = 1'b0;
      if (cclk && !prevC) begin
        got = {got[6:0], dout};
        rises++;
      end
      prevC = cclk;
      if (busy) busyCyc++;
    end
    endCyc = cyc;
    checkOutput({tag, " bits"}, {24'b0, got}, {24'b0, b});
    checkOutput({tag, " rises"}, rises, 32'd8);
    checkOutput({tag, " busy cycles"}, busyCyc, 16 * HALF);
    checkOutput({tag, " end dout"}, {31'b0, dout}, {31'b0, b[0]});
    checkOutput({tag, " end cclk"}, {31'b0, cclk}, 32'd0);
  endtask

  initial begin
    int rises;
    logic prevC;
    compared = 0;
    mismatched = 0;
    cyc = 0;
    rstN = 1'b0;
    dataIn = '0;
    newData = 1'b0;
    doneIn = 1'b0;
    abortIn = 1'b0;
    #12;
    checkOutput("reset cclk", {31'b0, cclk}, 32'd0);
    checkOutput("reset dout", {31'b0, dout}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset ready", {31'b0, readySent}, 32'd0);
    rstN = 1'b1;
    tick();
    tick();

    $display("[TB] single byte A5");
    applyStimulus(8'hA5, 1'b0, 1'b0, "A5");

    $display("[TB] back-to-back 00 then FF");
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, "B2B 00");
    prevEnd = endCyc;
    applyStimulus(8'hFF, 1'b0, 1'b0, "B2B FF");
    checkOutput("B2B gap", startCyc - prevEnd, 32'd1);

    $display("[TB] async reset mid-shift");
    dataIn = 8'hF0;
    newData = 1'b1;
    tick();
    newData = 1'b0;
    repeat (30) tick();
    checkOutput("pre-reset cclk", {31'b0, cclk}, 32'd1);
    rstN = 1'b0;
    #2;
    checkOutput("midrst cclk", {31'b0, cclk}, 32'd0);
    checkOutput("midrst dout", {31'b0, dout}, 32'd0);
    checkOutput("midrst busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst ready", {31'b0, readySent}, 32'd0);
    #2;
    rstN = 1'b1;
    tick();
    tick();

    $display("[TB] ready hold");
    doneIn = 1'b1;
    tick();
    doneIn = 1'b0;
    checkOutput("hold cclk", {31'b0, cclk}, 32'd1);
    checkOutput("hold busy", {31'b0, busy}, 32'd1);
    checkOutput("hold ready early", {31'b0, readySent}, 32'd0);
    repeat (HOLD - 1) tick();
    checkOutput("hold ready at 15", {31'b0, readySent}, 32'd0);
    checkOutput("hold cclk at 15", {31'b0, cclk}, 32'd1);
    tick();
    checkOutput("hold ready at 16", {31'b0, readySent}, 32'd1);
    dataIn = 8'h81;
    newData = 1'b1;
    tick();
    newData = 1'b0;
    repeat (40) tick();
    checkOutput("ready ignores byte ready", {31'b0, readySent}, 32'd1);
    checkOutput("ready ignores byte cclk", {31'b0, cclk}, 32'd1);
    checkOutput("ready ignores byte busy", {31'b0, busy}, 32'd1);

    $display("[TB] abort in READY");
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    checkOutput("abort ready ready", {31'b0, readySent}, 32'd0);
    checkOutput("abort ready cclk", {31'b0, cclk}, 32'd0);
    checkOutput("abort ready busy", {31'b0, busy}, 32'd0);
    checkOutput("abort ready dout", {31'b0, dout}, 32'd0);
    tick();

    $display("[TB] abort during bit 3 of C3");
    dataIn = 8'hC3;
    newData = 1'b1;
    tick();
    newData = 1'b0;
    rises = 0;
    prevC = cclk;
    for (int i = 0; i < 16 * HALF && rises < 5; i++) begin
      tick();
      if (cclk && !prevC) rises++;
      prevC = cclk;
    end
    checkOutput("abort bit3 reached", rises, 32'd5);
    checkOutput("abort bit3 dout", {31'b0, dout}, 32'd0);
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    checkOutput("abort shift cclk", {31'b0, cclk}, 32'd0);
    checkOutput("abort shift busy", {31'b0, busy}, 32'd0);
    rises = 0;
    prevC = cclk;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cclk && !prevC) rises++;
      prevC = cclk;
    end
    checkOutput("abort no pulses", rises, 32'd0);
    applyStimulus(8'h3C, 1'b0, 1'b0, "after abort 3C");

    $display("[TB] simultaneous strobes and done while busy");
    tick();
    applyStimulus(8'h5A, 1'b1, 1'b0, "new+done");
    repeat (3) tick();
    checkOutput("new+done no hold busy", {31'b0, busy}, 32'd0);
    checkOutput("new+done no hold cclk", {31'b0, cclk}, 32'd0);
    applyStimulus(8'h96, 1'b0, 1'b1, "done mid");
    repeat (3) tick();
    checkOutput("done mid ignored busy", {31'b0, busy}, 32'd0);
    checkOutput("done mid ignored cclk", {31'b0, cclk}, 32'd0);
    checkOutput("done mid ignored ready", {31'b0, readySent}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
